// File: rtl/ctrl_pkg.sv
// Shared encodings for the ARM-subset control unit: ALU opcodes, condition
// codes, instruction classes, extender modes and sequencer states.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_ORR   = 4'b0011,
    ALU_EOR   = 4'b0100,
    ALU_PASSB = 4'b0101
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_NOP = 2'b11
  } op_t;

  // Data-processing cmd field values the controller acts on
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  typedef logic [0:0] state_t;
  localparam state_t ST_RUN      = 1'b0;
  localparam state_t ST_MEM_WAIT = 1'b1;

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the NZCV flags; purely combinational.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ok
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_EQ: cond_ok = z;
      COND_NE: cond_ok = ~z;
      COND_CS: cond_ok = c;
      COND_CC: cond_ok = ~c;
      COND_MI: cond_ok = n;
      COND_PL: cond_ok = ~n;
      COND_VS: cond_ok = v;
      COND_VC: cond_ok = ~v;
      COND_HI: cond_ok = c & ~z;
      COND_LS: cond_ok = ~c | z;
      COND_GE: cond_ok = (n == v);
      COND_LT: cond_ok = (n != v);
      COND_GT: cond_ok = ~z & (n == v);
      COND_LE: cond_ok = z | (n != v);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_mem_controller.sv
// Control unit for the single-cycle ARM-subset datapath: decode, NZCV flags,
// condition gating and a wait-state/timeout handshake with data memory.
//   state       | meaning
//   ST_RUN      | issuing instructions; a memory op not ready here moves to wait
//   ST_MEM_WAIT | PC held, access outstanding, wait_cnt counts stalled cycles
module cond_mem_controller
  import ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [3:0]  ALUControl,
  output logic        MemtoReg,
  output logic        PCSrc,
  output logic        MemWrite,
  output logic        MemReq,
  output logic        PCEn,
  output logic [3:0]  Flags,
  output logic        BusError
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       i_bit, s_bit, u_bit;
  logic       unused_rn;

  // Instr carries bits [31:12] of the instruction word
  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign i_bit     = Instr[13];
  assign cmd       = Instr[12:9];
  assign u_bit     = Instr[11];
  assign s_bit     = Instr[8];
  assign rd        = Instr[3:0];
  assign unused_rn = &{1'b0, Instr[7:4]};

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        flags_q;
  logic              bus_error_q;
  logic              cond_ok;

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ok (cond_ok)
  );

  alu_op_t    alu_ctl;
  logic [1:0] reg_src, imm_src;
  logic       alu_src, dp_write, is_cmp, cv_upd, is_mem, is_load, is_br;

  always_comb begin
    reg_src  = 2'b00;
    imm_src  = IMM_DP;
    alu_src  = 1'b0;
    alu_ctl  = ALU_ADD;
    dp_write = 1'b0;
    is_cmp   = 1'b0;
    cv_upd   = 1'b0;
    is_mem   = 1'b0;
    is_load  = 1'b0;
    is_br    = 1'b0;
    case (op)
      OP_DP: begin
        alu_src = i_bit;
        case (cmd)
          CMD_AND: begin alu_ctl = ALU_AND;   dp_write = 1'b1; end
          CMD_EOR: begin alu_ctl = ALU_EOR;   dp_write = 1'b1; end
          CMD_SUB: begin alu_ctl = ALU_SUB;   dp_write = 1'b1; cv_upd = 1'b1; end
          CMD_ADD: begin alu_ctl = ALU_ADD;   dp_write = 1'b1; cv_upd = 1'b1; end
          CMD_ORR: begin alu_ctl = ALU_ORR;   dp_write = 1'b1; end
          CMD_MOV: begin alu_ctl = ALU_PASSB; dp_write = 1'b1; end
          CMD_CMP: begin alu_ctl = ALU_SUB;   is_cmp   = 1'b1; cv_upd = 1'b1; end
          default: ;
        endcase
      end
      OP_MEM: begin
        alu_src    = 1'b1;
        imm_src    = IMM_MEM;
        alu_ctl    = u_bit ? ALU_ADD : ALU_SUB;
        is_mem     = 1'b1;
        is_load    = s_bit;
        reg_src[1] = ~s_bit;
      end
      OP_BR: begin
        reg_src[0] = 1'b1;
        imm_src    = IMM_BR;
        alu_src    = 1'b1;
        is_br      = 1'b1;
      end
      default: ;
    endcase
  end

  logic mem_active, mem_done, abort, wr_en, flag_we;

  // Instr is frozen while waiting, so the access stays live regardless of cond_ok
  assign mem_active = reset & ((state == ST_MEM_WAIT) | (is_mem & cond_ok));
  assign mem_done   = mem_active & MemReady;
  assign abort      = reset & (state == ST_MEM_WAIT) & ~MemReady & (wait_cnt == MAX_CNT);
  assign wr_en      = reset & ((cond_ok & dp_write) | (is_load & mem_done));
  assign flag_we    = (state == ST_RUN) & cond_ok & (op == OP_DP) & (is_cmp | (s_bit & dp_write));

  assign RegSrc     = reg_src;
  assign ImmSrc     = imm_src;
  assign ALUSrc     = alu_src;
  assign ALUControl = alu_ctl;
  assign RegWrite   = wr_en;
  assign MemtoReg   = is_load & mem_done;
  assign PCSrc      = reset & ((cond_ok & is_br) | (wr_en & (rd == 4'hF)));
  assign MemReq     = mem_active;
  assign MemWrite   = mem_active & ~is_load & ~abort;
  assign PCEn       = reset & (mem_active ? (MemReady | abort) : 1'b1);
  assign Flags      = flags_q;
  assign BusError   = bus_error_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      flags_q     <= 4'b0000;
      bus_error_q <= 1'b0;
    end else begin
      if (flag_we) begin
        flags_q[3:2] <= ALUFlags[3:2];
        if (cv_upd) flags_q[1:0] <= ALUFlags[1:0];
      end
      if (state == ST_RUN) begin
        if (mem_active && !MemReady) begin
          state    <= ST_MEM_WAIT;
          wait_cnt <= WAIT_W'(1);
        end
      end else begin
        if (MemReady) begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end else if (abort) begin
          state       <= ST_RUN;
          wait_cnt    <= '0;
          bus_error_q <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_mem_controller.sv
// Directed bench for cond_mem_controller: an instruction-level reference model
// checked every cycle, plus literal expectations at the interesting points.
module tb_cond_mem_controller;

  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] instr = 20'hEC000;
  logic [3:0]  alu_flags = 4'b0000;
  logic        mem_ready = 1'b0;
  logic [1:0]  reg_src, imm_src;
  logic        reg_write, alu_src, mem_to_reg, pc_src, mem_write, mem_req, pc_en, bus_error;
  logic [3:0]  alu_control, flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_mem_controller #(.MAX_WAIT(MAXW), .WAIT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (instr),
    .ALUFlags   (alu_flags),
    .MemReady   (mem_ready),
    .RegSrc     (reg_src),
    .RegWrite   (reg_write),
    .ImmSrc     (imm_src),
    .ALUSrc     (alu_src),
    .ALUControl (alu_control),
    .MemtoReg   (mem_to_reg),
    .PCSrc      (pc_src),
    .MemWrite   (mem_write),
    .MemReq     (mem_req),
    .PCEn       (pc_en),
    .Flags      (flags),
    .BusError   (bus_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] reg_src;
    logic       reg_write;
    logic [1:0] imm_src;
    logic       alu_src;
    logic [3:0] alu_control;
    logic       mem_to_reg;
    logic       pc_src;
    logic       mem_write;
    logic       mem_req;
    logic       pc_en;
  } ctl_t;

  logic [3:0] m_flags = 4'b0000;
  int         m_spent = 0;   // MemReq cycles already spent on the current access
  logic       m_berr  = 1'b0;

  // ARM pairs: even code tests a predicate, odd code is its inverse
  function automatic logic arm_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    logic [2:0] grp;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    grp = c[3:1];
    case (grp)
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return base ^ c[0];
  endfunction

  function automatic ctl_t model_out(input logic [19:0] ins, input logic [3:0] fl,
                                     input logic rdy, input int spent, input logic rst);
    ctl_t e;
    logic pass, ld, done, abrt, wr;
    logic [3:0] cmd, rd;
    int k;
    e = '0;
    e.pc_en = 1'b1;
    pass = arm_pass(ins[19:16], fl);
    cmd = ins[12:9];
    rd = ins[3:0];
    k = int'(ins[15:14]);
    if (k == 0) begin
      e.alu_src = ins[13];
      wr = 1'b1;
      if (cmd == 4'b0000) e.alu_control = 4'd2;
      else if (cmd == 4'b0001) e.alu_control = 4'd4;
      else if (cmd == 4'b0010) e.alu_control = 4'd1;
      else if (cmd == 4'b0100) e.alu_control = 4'd0;
      else if (cmd == 4'b1100) e.alu_control = 4'd3;
      else if (cmd == 4'b1101) e.alu_control = 4'd5;
      else begin
        wr = 1'b0;
        e.alu_control = (cmd == 4'b1010) ? 4'd1 : 4'd0;
      end
      e.reg_write = pass && wr;
      e.pc_src = pass && wr && (rd == 4'd15);
    end else if (k == 1) begin
      ld = ins[8];
      e.alu_src = 1'b1;
      e.imm_src = 2'd1;
      e.alu_control = ins[11] ? 4'd0 : 4'd1;
      e.reg_src = ld ? 2'b00 : 2'b10;
      if (pass) begin
        done = rdy;
        abrt = !rdy && (spent == MAXW);
        e.mem_req = 1'b1;
        e.pc_en = done || abrt;
        e.reg_write = ld && done;
        e.mem_to_reg = ld && done;
        e.pc_src = ld && done && (rd == 4'd15);
        e.mem_write = !ld && !abrt;
      end
    end else if (k == 2) begin
      e.reg_src = 2'b01;
      e.imm_src = 2'd2;
      e.alu_src = 1'b1;
      e.alu_control = 4'd0;
      e.pc_src = pass;
    end
    if (!rst) begin
      e.reg_write = 1'b0; e.mem_write = 1'b0; e.mem_req = 1'b0;
      e.pc_src = 1'b0; e.pc_en = 1'b0; e.mem_to_reg = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    ctl_t e;
    logic pass;
    logic [3:0] cmd;
    if (!reset) begin
      m_flags = 4'b0000; m_spent = 0; m_berr = 1'b0;
    end
    e = model_out(instr, m_flags, mem_ready, m_spent, reset);
    chk("reg_src",     reg_src,     e.reg_src);
    chk("reg_write",   reg_write,   e.reg_write);
    chk("imm_src",     imm_src,     e.imm_src);
    chk("alu_src",     alu_src,     e.alu_src);
    chk("alu_control", alu_control, e.alu_control);
    chk("mem_to_reg",  mem_to_reg,  e.mem_to_reg);
    chk("pc_src",      pc_src,      e.pc_src);
    chk("mem_write",   mem_write,   e.mem_write);
    chk("mem_req",     mem_req,     e.mem_req);
    chk("pc_en",       pc_en,       e.pc_en);
    chk("flags",       flags,       m_flags);
    chk("bus_error",   bus_error,   m_berr);
    if (reset) begin
      pass = arm_pass(instr[19:16], m_flags);
      cmd = instr[12:9];
      if (pass && instr[15:14] == 2'b00) begin
        if (cmd == 4'b1010) m_flags = alu_flags;
        else if (instr[8] && (cmd == 4'b0010 || cmd == 4'b0100)) m_flags = alu_flags;
        else if (instr[8] && (cmd == 4'b0000 || cmd == 4'b0001 || cmd == 4'b1100 || cmd == 4'b1101))
          m_flags = {alu_flags[3:2], m_flags[1:0]};
      end
      if (pass && instr[15:14] == 2'b01) begin
        if (mem_ready) m_spent = 0;
        else if (m_spent == MAXW) begin m_spent = 0; m_berr = 1'b1; end
        else m_spent = m_spent + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [19:0] ADDS   = 20'hE0921;
  localparam logic [19:0] BEQ    = 20'h0A000;
  localparam logic [19:0] LDR    = 20'hE5910;
  localparam logic [19:0] STR    = 20'hE5810;
  localparam logic [19:0] CMP    = 20'hE1510;
  localparam logic [19:0] NVADDS = 20'hF0921;
  localparam logic [19:0] IDLE   = 20'hEC000;

  task automatic cyc(input logic rst, input logic [19:0] i, input logic [3:0] a, input logic r);
    @(posedge clk);
    #1;
    reset = rst; instr = i; alu_flags = a; mem_ready = r;
    @(negedge clk);
    #1;
  endtask

  logic [19:0] vec_i [18] = '{
    20'hE0112, 20'hE0921, 20'hE0334, 20'hE0445, 20'hE3996, 20'hE3A0F,
    20'hE081F, 20'hE0777, 20'h13B01, 20'hE511F, 20'hE5013, 20'hE5013,
    20'hE5013, 20'hE5013, 20'h15910, 20'hAA000, 20'hBA000, 20'hEC000 };
  logic [3:0]  vec_a [18] = '{
    4'b1111, 4'b0011, 4'b1000, 4'b0101, 4'b0100, 4'b0000,
    4'b0000, 4'b1111, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
    4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000 };
  logic        vec_r [18] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0 };

  initial begin
    // held in reset
    cyc(0, ADDS, 4'b0110, 0);
    cyc(0, ADDS, 4'b0110, 1);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_berr", bus_error, 0);
    chk("rst_pcen", pc_en, 0);
    chk("rst_regwrite", reg_write, 0);

    cyc(1, ADDS, 4'b0110, 0);
    chk("adds_regwrite", reg_write, 1);
    chk("adds_aluctl", alu_control, 4'b0000);
    chk("adds_pcen", pc_en, 1);
    cyc(1, BEQ, 4'b0000, 0);
    chk("adds_flags", flags, 4'b0110);
    chk("beq_taken_pcsrc", pc_src, 1);
    chk("beq_immsrc", imm_src, 2'b10);
    chk("beq_regsrc", reg_src, 2'b01);
    cyc(1, ADDS, 4'b0000, 0);
    cyc(1, BEQ, 4'b0000, 0);
    chk("beq_nt_pcsrc", pc_src, 0);
    chk("beq_nt_pcen", pc_en, 1);

    for (int i = 0; i < 3; i++) begin
      cyc(1, LDR, 4'b0000, 0);
      chk("ldr_wait_pcen", pc_en, 0);
      chk("ldr_wait_req", mem_req, 1);
      chk("ldr_wait_regwrite", reg_write, 0);
    end
    cyc(1, LDR, 4'b0000, 1);
    chk("ldr_done_regwrite", reg_write, 1);
    chk("ldr_done_memtoreg", mem_to_reg, 1);
    chk("ldr_done_pcen", pc_en, 1);
    cyc(1, IDLE, 4'b0000, 1);
    chk("idle_req", mem_req, 0);

    cyc(1, CMP, 4'b0100, 0);
    chk("cmp_regwrite", reg_write, 0);
    chk("cmp_aluctl", alu_control, 4'b0001);
    cyc(1, NVADDS, 4'b1111, 1);
    chk("cmp_flags", flags, 4'b0100);
    chk("nv_regwrite", reg_write, 0);
    chk("nv_pcen", pc_en, 1);
    cyc(1, IDLE, 4'b0000, 0);
    chk("nv_flags", flags, 4'b0100);

    for (int i = 0; i < 18; i++) cyc(1, vec_i[i], vec_a[i], vec_r[i]);
    chk("vec_flags", flags, 4'b0111);

    // stuck store: 15 stalled cycles then the abort cycle
    for (int i = 0; i < MAXW; i++) begin
      cyc(1, STR, 4'b0000, 0);
      chk("str_req", mem_req, 1);
      chk("str_write", mem_write, 1);
      chk("str_pcen", pc_en, 0);
    end
    cyc(1, STR, 4'b0000, 0);
    chk("abort_req", mem_req, 1);
    chk("abort_write", mem_write, 0);
    chk("abort_pcen", pc_en, 1);
    chk("abort_berr_pre", bus_error, 0);
    cyc(1, IDLE, 4'b0000, 0);
    chk("abort_berr", bus_error, 1);
    cyc(1, ADDS, 4'b1000, 1);
    cyc(1, LDR, 4'b0000, 1);
    chk("berr_sticky", bus_error, 1);

    // reset in the middle of a wait
    cyc(1, LDR, 4'b0000, 0);
    cyc(1, LDR, 4'b0000, 0);
    cyc(0, LDR, 4'b0000, 0);
    chk("midrst_regwrite", reg_write, 0);
    chk("midrst_req", mem_req, 0);
    chk("midrst_pcen", pc_en, 0);
    chk("midrst_berr", bus_error, 0);
    cyc(1, IDLE, 4'b0000, 1);
    chk("post_rst_pcen", pc_en, 1);
    chk("post_rst_req", mem_req, 0);
    cyc(1, IDLE, 4'b0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
